// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: forwards same-cycle writes/reservations and holds the output registers.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stor_word,
  input  logic                     busy_bit,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic [DATA_W-1:0] data_nxt_s;
  logic              busy_nxt_s;
  logic              is_zero_s;
  logic [DATA_W-1:0] data_r;
  logic              busy_r;

  // Resolve the post-edge view of the addressed register; ascending loop lets the higher write port win.
  always_comb begin
    data_nxt_s = stor_word;
    busy_nxt_s = busy_bit;
    is_zero_s  = (ZERO_REG != 0) && (rd_addr == {ADDR_W{1'b0}});
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
        data_nxt_s = wr_data[j*DATA_W +: DATA_W];
        busy_nxt_s = 1'b0;
      end else begin
        data_nxt_s = data_nxt_s;
      end
    end
    // A reservation issued alongside a write belongs to a newer producer.
    if (rsv_en && (rsv_addr == rd_addr)) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (is_zero_s) begin
      data_nxt_s = {DATA_W{1'b0}};
      busy_nxt_s = 1'b0;
    end else begin
      data_nxt_s = data_nxt_s;
    end
  end

  // Output registers update only on an enabled read, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {DATA_W{1'b0}};
      busy_r <= 1'b0;
    end else if (rd_en) begin
      data_r <= data_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  assign rd_data = data_r;
  assign rd_busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write forwarding, write priority and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [NUM_WR-1:0] wr_ok_s;
  logic              rsv_ok_s;

  // Qualify writes and reservations against the hardwired zero register.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok_s[j] = wr_en[j] &&
                   !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}));
    end
    rsv_ok_s = rsv_en && !((ZERO_REG != 0) && (rsv_addr == {ADDR_W{1'b0}}));
  end

  // Storage: later loop iterations overwrite earlier ones, so the highest write port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok_s[j]) begin
          mem_r[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Busy scoreboard: writes clear, a reservation afterwards sets and so wins a same-address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok_s[j]) begin
          busy_r[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsv_ok_s) begin
        busy_r[rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en[k]),
      .rd_addr   (addr_s),
      .stor_word (mem_r[addr_s]),
      .busy_bit  (busy_r[addr_s]),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .rd_data   (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy   (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;

  int checks_r;
  int failures_r;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en  = '0;
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input word_t d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_en[p]             = 1'b1;
    rd_addr[p*AW +: AW]  = a;
  endtask

  function automatic word_t rdat(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_n      = 1'b0;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    rsv_addr   = '0;
    idle();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_rd0", rdat(0), 32'h0);
    check("rst_rd1", rdat(1), 32'h0);
    check("rst_busy", {30'd0, rd_busy}, 32'h0);

    // Reset mid-traffic
    idle(); wr(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); rd(0, 5'd5); tick();
    check("pre_rst_r5", rdat(0), 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd0", rdat(0), 32'h0);
    #2 rst_n = 1'b1;
    idle(); rd(0, 5'd5); tick();
    check("post_rst_r5", rdat(0), 32'h0);

    // Forwarding
    idle(); wr(0, 5'd7, 32'h11); tick();
    idle(); wr(0, 5'd7, 32'h1234); rd(1, 5'd7); tick();
    check("fwd_r7", rdat(1), 32'h1234);

    // Collision, same-cycle read then later read
    idle(); wr(0, 5'd3, 32'hAAAA); wr(1, 5'd3, 32'h5555); rd(0, 5'd3); tick();
    check("coll_fwd", rdat(0), 32'h5555);
    idle(); rd(1, 5'd3); tick();
    check("coll_later", rdat(1), 32'h5555);

    // Zero register
    idle(); wr(0, 5'd0, 32'hFFFFFFFF); wr(1, 5'd0, 32'hFFFFFFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0; rd(0, 5'd0); tick();
    check("zero_fwd_data", rdat(0), 32'h0);
    check("zero_fwd_busy", {31'd0, rd_busy[0]}, 32'h0);
    idle(); rd(1, 5'd0); tick();
    check("zero_data", rdat(1), 32'h0);
    check("zero_busy", {31'd0, rd_busy[1]}, 32'h0);

    // Scoreboard
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9; tick();
    idle(); rd(0, 5'd9); tick();
    check("sb_busy_set", {31'd0, rd_busy[0]}, 32'h1);
    idle(); wr(1, 5'd9, 32'h42); rd(0, 5'd9); tick();
    check("sb_wr_busy", {31'd0, rd_busy[0]}, 32'h0);
    check("sb_wr_data", rdat(0), 32'h42);
    idle(); wr(0, 5'd9, 32'h43); rsv_en = 1'b1; rsv_addr = 5'd9; rd(1, 5'd9); tick();
    check("sb_rsv_wins_fwd", {31'd0, rd_busy[1]}, 32'h1);
    check("sb_rsv_wins_data", rdat(1), 32'h43);
    idle(); rd(0, 5'd9); tick();
    check("sb_rsv_wins_later", {31'd0, rd_busy[0]}, 32'h1);

    // Read hold
    idle(); wr(1, 5'd4, 32'h77); tick();
    idle(); rd(0, 5'd4); tick();
    check("hold_init", rdat(0), 32'h77);
    idle(); rd_addr[0 +: AW] = 5'd8; wr(0, 5'd4, 32'h99); tick();
    check("hold_1", rdat(0), 32'h77);
    idle(); tick();
    check("hold_2", rdat(0), 32'h77);
    idle(); rd(0, 5'd4); tick();
    check("hold_release", rdat(0), 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the core's 32x32 two-read/one-write register file.
- Serves the integer datapath that feeds the ALU.
- Adds a configurable number of read and write ports, per-port read enable, and write-to-read forwarding across all write ports.
- Adds deterministic write-port priority, an optional hardwired zero register, and a per-register busy scoreboard for in-flight results.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and reservations, and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k occupies slice [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered busy flag of the addressed register.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- rsv_en  in  1  mark a register busy (result pending).
- rsv_addr  in  ADDR_W  register to reserve.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: all storage registers = 0, rd_data = 0, rd_busy = 0, all busy bits = 0. Reset takes effect immediately, mid-operation included. A write or reservation in the cycle reset asserts is discarded.
- Write: on the rising edge, storage[wr_addr[j]] <= wr_data[j] for each j with wr_en[j]=1.
- Write collision: if two write ports target the same address, the higher port index wins.
- Zero register: when ZERO_REG=1, writes to address 0 are dropped.
- Read latency: 1 cycle. With rd_en[k]=1 on edge t, rd_data[k] after t equals the value of storage[rd_addr[k]] after the edge-t updates. This is write-through forwarding:
  - a same-cycle write to that address returns the new data;
  - the winning port's data is returned on a collision.
- Read hold: with rd_en[k]=0, rd_data[k] and rd_busy[k] hold their previous values.
- Zero register read: when ZERO_REG=1, a read of address 0 returns 0 and rd_busy = 0.
- Scoreboard: one busy bit per register.
  - rsv_en sets busy[rsv_addr].
  - A write by any port clears busy[wr_addr].
  - If a reservation and a write target the same address in the same cycle, the reservation wins and busy stays 1 (a new producer has been issued).
  - Reserving an address that is already busy keeps it busy.
- rd_busy[k] forwards on the same basis as data: it reflects the busy bit after the edge-t updates.
- Port independence: read ports are independent. Any number of them may use the same address.
- Structure: no state machine; storage, busy vector and output registers only.
- Widths: no arithmetic. Addresses are compared at full ADDR_W bits.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the typedef for a register word;
  - the typedef for an address.
- One sub-module: regfile_rd_port, instantiated NUM_RD times.
  - Inputs: storage word, busy bit, write-port buses, rd_en.
  - Computes the forwarded next value with priority resolution.
  - Holds the per-port output registers.
- Top level holds storage, the busy vector, write decode and reservation logic.

Test Plan:
- Reset mid-traffic: write 0xDEADBEEF to r5, read r5, then pulse rst_n low between edges. Required: rd_data = 0 immediately. After release, a read of r5 returns 0.
- Forwarding: with r7 = 0x11 from earlier, write port0 r7 = 0x1234 while port1 reads r7 in the same cycle. Required: rd_data[1] = 0x1234 one cycle later.
- Collision: port0 writes r3 = 0xAAAA and port1 writes r3 = 0x5555 in the same cycle. Required: a later read of r3 returns 0x5555, and a same-cycle read also returns 0x5555.
- Zero register: with ZERO_REG=1, write r0 = 0xFFFFFFFF and reserve r0. Required: a read of r0 returns 0 with rd_busy = 0.
- Scoreboard: reserve r9, then read r9 (busy = 1). Write r9 = 0x42 while reading it (busy = 0, data 0x42). Reserve and write r9 in the same cycle; a read then shows busy = 1.
- Read hold: read r4 = 0x77 with rd_en = 1, then set rd_en = 0, change rd_addr to r8 and write r4 = 0x99. Required: rd_data stays 0x77 until rd_en returns to 1.
